// File: rtl/fpu_pkg.sv
// Shared FPU definitions: control codes, compare-stage FSM states and
// single-precision field constants.
package fpu_pkg;

    localparam logic [3:0] FCMP_EQ = 4'b1010;
    localparam logic [3:0] FCMP_LT = 4'b1011;
    localparam logic [3:0] FCMP_LE = 4'b1100;

    localparam logic [7:0] EXP_MAX   = 8'hFF;
    localparam int unsigned QUIET_BIT = 22;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } fcmp_state_e;

endpackage

// File: rtl/fp_nan_classify.sv
// Combinational NaN / signalling-NaN detector for an IEEE-754 single operand.
module fp_nan_classify
    import fpu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] operand,
    output logic            is_nan,
    output logic            is_snan
);

    logic [7:0]  exp_f;
    logic [22:0] mant_f;

    assign exp_f   = operand[30:23];
    assign mant_f  = operand[22:0];
    assign is_nan  = (exp_f == EXP_MAX) && (mant_f != '0);
    assign is_snan = is_nan && !mant_f[QUIET_BIT];

endmodule

// File: rtl/fcmp_seq_stage.sv
// Registered wrapper around the combinational FP comparator for FEQ/FLT/FLE:
// handshake in, one evaluation cycle, held response out, sticky NV flag.
module fcmp_seq_stage
    import fpu_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CTRL_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [XLEN-1:0]   REQ_A,
    input  logic [XLEN-1:0]   REQ_B,
    input  logic [CTRL_W-1:0] REQ_CTRL,
    output logic [XLEN-1:0]   CMP_A,
    output logic [XLEN-1:0]   CMP_B,
    output logic [CTRL_W-1:0] CMP_CTRL,
    input  logic [XLEN-1:0]   CMP_R,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [XLEN-1:0]   RSP_DATA,
    output logic              RSP_NV,
    output logic              RSP_ILL,
    input  logic              FLAG_CLR,
    output logic              FFLAGS_NV
);

    fcmp_state_e state, next_state;

    logic a_nan, a_snan, b_nan, b_snan;
    logic [XLEN-1:0] eval_data;
    logic            eval_nv;
    logic            eval_ill;
    logic            unused_cmp_hi;

    assign unused_cmp_hi = ^CMP_R[XLEN-1:1];

    fp_nan_classify #(.XLEN(XLEN)) u_class_a (
        .operand (CMP_A),
        .is_nan  (a_nan),
        .is_snan (a_snan)
    );

    fp_nan_classify #(.XLEN(XLEN)) u_class_b (
        .operand (CMP_B),
        .is_nan  (b_nan),
        .is_snan (b_snan)
    );

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        REQ_READY  = 1'b0;
        RSP_VALID  = 1'b0;
        unique case (state)
            IDLE: begin
                REQ_READY = 1'b1;
                if (REQ_VALID) next_state = EVAL;
            end
            EVAL: next_state = DONE;
            DONE: begin
                RSP_VALID = 1'b1;
                if (RSP_READY) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // FEQ only signals on sNaN; ordered compares signal on any NaN.
    always_comb begin
        eval_data = '0;
        eval_nv   = 1'b0;
        eval_ill  = 1'b0;
        if (CMP_CTRL == CTRL_W'(FCMP_EQ)) begin
            eval_data[0] = CMP_R[0] && !(a_nan || b_nan);
            eval_nv      = a_snan || b_snan;
        end else if (CMP_CTRL == CTRL_W'(FCMP_LT) || CMP_CTRL == CTRL_W'(FCMP_LE)) begin
            eval_data[0] = CMP_R[0] && !(a_nan || b_nan);
            eval_nv      = a_nan || b_nan;
        end else begin
            eval_ill = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            CMP_A    <= '0;
            CMP_B    <= '0;
            CMP_CTRL <= '0;
            RSP_DATA <= '0;
            RSP_NV   <= 1'b0;
            RSP_ILL  <= 1'b0;
        end else begin
            if (state == IDLE && REQ_VALID) begin
                CMP_A    <= REQ_A;
                CMP_B    <= REQ_B;
                CMP_CTRL <= REQ_CTRL;
            end
            if (state == EVAL) begin
                RSP_DATA <= eval_data;
                RSP_NV   <= eval_nv;
                RSP_ILL  <= eval_ill;
            end
        end
    end

    // A handoff carrying NV takes priority over a coincident clear.
    always_ff @(posedge CLK) begin
        if (RST)                                        FFLAGS_NV <= 1'b0;
        else if (state == DONE && RSP_READY && RSP_NV)  FFLAGS_NV <= 1'b1;
        else if (FLAG_CLR)                              FFLAGS_NV <= 1'b0;
    end

endmodule

// File: tb/tb_fcmp_seq_stage.sv
// Scoreboard bench for fcmp_seq_stage with a behavioural comparator stub.
module tb_fcmp_seq_stage;

    localparam logic [3:0] C_EQ = 4'b1010;
    localparam logic [3:0] C_LT = 4'b1011;
    localparam logic [3:0] C_LE = 4'b1100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = '0, req_b = '0;
    logic [3:0]  req_ctrl = '0;
    logic [31:0] cmp_a, cmp_b, cmp_r;
    logic [3:0]  cmp_ctrl;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_nv, rsp_ill;
    logic        flag_clr = 1'b0;
    logic        fflags_nv;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        nv;
        logic        ill;
    } rsp_t;
    rsp_t exp_q[$];

    always #5 clk = ~clk;

    fcmp_seq_stage #(.XLEN(32), .CTRL_W(4)) dut (
        .CLK(clk), .RST(rst),
        .REQ_VALID(req_valid), .REQ_READY(req_ready),
        .REQ_A(req_a), .REQ_B(req_b), .REQ_CTRL(req_ctrl),
        .CMP_A(cmp_a), .CMP_B(cmp_b), .CMP_CTRL(cmp_ctrl), .CMP_R(cmp_r),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready),
        .RSP_DATA(rsp_data), .RSP_NV(rsp_nv), .RSP_ILL(rsp_ill),
        .FLAG_CLR(flag_clr), .FFLAGS_NV(fflags_nv)
    );

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction

    // Comparator stub: junk in upper bits, and asserts bit 0 on NaN or unknown code
    // so the stage's masking is exercised.
    function automatic logic [31:0] cmp_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] c);
        logic eq, lt, r;
        if (is_nan(a) || is_nan(b)) return 32'hFFFF_FFFF;
        eq = (a == b) || (a[30:0] == 0 && b[30:0] == 0);
        if (eq)                lt = 1'b0;
        else if (a[31] != b[31]) lt = a[31];
        else if (!a[31])       lt = a[30:0] < b[30:0];
        else                   lt = a[30:0] > b[30:0];
        case (c)
            C_EQ:    r = eq;
            C_LT:    r = lt;
            C_LE:    r = lt | eq;
            default: return 32'hFFFF_FFFF;
        endcase
        return {31'h2AAA_AAAA, r};
    endfunction

    always_comb cmp_r = cmp_model(cmp_a, cmp_b, cmp_ctrl);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every handed-off response against the scoreboard.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_nv", {31'b0, rsp_nv}, {31'b0, e.nv});
                chk("rsp_ill", {31'b0, rsp_ill}, {31'b0, e.ill});
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", {31'b0, req_ready}, 32'd1);
    endtask

    // Issue one request and check the accept-to-valid latency.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                         input logic [31:0] ed, input logic env, input logic eill);
        wait_ready();
        req_a = a; req_b = b; req_ctrl = c; req_valid = 1'b1;
        exp_q.push_back('{data: ed, nv: env, ill: eill});
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("eval_no_valid", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        chk("latency_valid", {31'b0, rsp_valid}, 32'd1);
    endtask

    task automatic after_handoff(input string name, input logic exp_flag);
        @(posedge clk); #1;
        chk(name, {31'b0, fflags_nv}, {31'b0, exp_flag});
        chk("back_idle", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_cmp_a", cmp_a, 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_fflags", {31'b0, fflags_nv}, 32'd0);
        rst = 1'b0;

        issue(32'h3F80_0000, 32'h3F80_0000, C_EQ, 32'd1, 1'b0, 1'b0);
        after_handoff("feq_flag", 1'b0);
        issue(32'h7FC0_0000, 32'h3F80_0000, C_EQ, 32'd0, 1'b0, 1'b0);
        after_handoff("feq_qnan_flag", 1'b0);
        issue(32'h7FC0_0000, 32'h3F80_0000, C_LT, 32'd0, 1'b1, 1'b0);
        after_handoff("flt_qnan_flag", 1'b1);

        flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        chk("clr_alone", {31'b0, fflags_nv}, 32'd0);

        flag_clr = 1'b1;
        issue(32'h7F80_0001, 32'h0000_0000, C_EQ, 32'd0, 1'b1, 1'b0);
        after_handoff("clr_vs_set", 1'b1);
        flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        chk("clr_later", {31'b0, fflags_nv}, 32'd0);

        issue(32'h8000_0000, 32'h0000_0000, C_LE, 32'd1, 1'b0, 1'b0);
        after_handoff("fle_zero_flag", 1'b0);
        issue(32'h4000_0000, 32'h3F80_0000, C_LE, 32'd0, 1'b0, 1'b0);
        after_handoff("fle_gt_flag", 1'b0);

        rsp_ready = 1'b0;
        issue(32'h3F80_0000, 32'h4000_0000, C_LT, 32'd1, 1'b0, 1'b0);
        held = rsp_data;
        chk("bp_data_first", held, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("bp_stable", rsp_data, held);
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", {31'b0, rsp_valid}, 32'd0);
        chk("bp_release_ready", {31'b0, req_ready}, 32'd1);

        wait_ready();
        req_a = 32'h7F80_0001; req_b = 32'h7F80_0001; req_ctrl = C_LT; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ready", {31'b0, req_ready}, 32'd1);
        chk("abort_valid", {31'b0, rsp_valid}, 32'd0);
        chk("abort_flag", {31'b0, fflags_nv}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_rsp", {31'b0, rsp_valid}, 32'd0);
        chk("abort_flag_late", {31'b0, fflags_nv}, 32'd0);

        issue(32'h3F80_0000, 32'h3F80_0000, 4'b0000, 32'd0, 1'b0, 1'b1);
        after_handoff("ill_flag", 1'b0);

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
